vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 11, screen-memory address width (40x30 character cells).
REQ-002 SHALL have parameter DW, default 8, character-code data width.
REQ-003 SHALL have parameter STARVE, default 4, the number of consecutive denied cycles after which a CPU grant is forced.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 vga_req  input  1  single-cycle pulse requesting a read of vga_addr.
REQ-007 vga_addr  input  AW  VGA fetch address, valid with vga_req.
REQ-008 vga_valid  output  1  single-cycle pulse marking vga_data valid.
REQ-009 vga_data  output  DW  VGA read data.
REQ-010 vga_ovf  output  1  sticky flag set when a VGA request is lost.
REQ-011 cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-012 cpu_we  input  1  1 selects write, 0 selects read; held with cpu_req.
REQ-013 cpu_addr  input  AW  CPU address, held with cpu_req.
REQ-014 cpu_wdata  input  DW  CPU write data, held with cpu_req.
REQ-015 cpu_ack  output  1  single-cycle completion pulse.
REQ-016 cpu_rdata  output  DW  CPU read data, valid with cpu_ack on reads.
REQ-017 mem_en, mem_we  output  1 each  registered memory port strobes.
REQ-018 mem_addr, mem_wdata  output  AW, DW  registered memory port address and data.
REQ-019 mem_rdata  input  DW  memory read data, valid exactly one cycle after a read is issued with mem_en=1 and mem_we=0.

Function
REQ-020 SHALL issue at most one memory access per cycle, with back-to-back issue permitted.
REQ-021 SHALL evaluate requests at each rising edge in this priority order:
- forced CPU grant
- pending VGA request
- incoming vga_req
- CPU request
REQ-022 SHALL consider the CPU eligible only when cpu_req=1, no CPU read is in flight, and no cpu_ack is being driven in the current cycle.
REQ-023 SHALL register each grant onto mem_* so the access appears in the cycle after the sampling edge (cycle t+1).
REQ-024 SHALL, for a VGA grant, assert vga_valid with vga_data=mem_rdata in cycle t+2.
- Latency is 2 cycles when granted at arrival.
- Latency is 3 cycles when granted from pending.
REQ-025 SHALL, for a CPU write, assert cpu_ack in the same cycle as mem_we=1 (t+1).
REQ-026 SHALL, for a CPU read, assert cpu_ack with cpu_rdata=mem_rdata in cycle t+2.
REQ-027 SHALL keep a wait counter that increments on each edge where the CPU is eligible but not granted.
- The counter clears on a CPU grant and whenever the CPU is not eligible.
- The counter saturates at STARVE.
REQ-028 SHALL force a CPU grant at an edge where the wait counter equals STARVE.
REQ-029 SHALL store an incoming vga_req (with its address) that is not granted at arrival in a one-deep pending register.
REQ-030 SHALL, if vga_req arrives while a pending request exists and is not granted at that edge, drop the new request, keep the pending one, and set vga_ovf.
REQ-031 SHALL, when the pending request is granted at the same edge a new vga_req arrives, move the new request into the pending register with no overflow.
REQ-032 SHALL clear vga_ovf only on reset.
REQ-033 SHALL hold mem_en=0 in idle cycles, with mem_addr and mem_wdata holding their last values.

Reset
REQ-034 SHALL, while reset=0, immediately force the following:
- mem_en, mem_we, vga_valid, cpu_ack and vga_ovf to 0
- mem_addr, mem_wdata, vga_data and cpu_rdata to 0
- the pending register and in-flight tracking cleared
- the wait counter to 0
REQ-035 SHALL discard any in-flight access on reset, asserting no vga_valid or cpu_ack for it after reset is released.
REQ-036 SHALL begin arbitration on the first rising edge after reset returns to 1.

Verification
REQ-037 Isolated vga_req at addr 0x12A with memory 0x12A=0x41 -> mem_en=1, mem_we=0, mem_addr=0x12A at t+1; vga_valid=1, vga_data=0x41 at t+2; vga_ovf=0.
REQ-038 cpu_req write to addr 0x005 with data 0x7F, no VGA traffic -> mem_we=1, mem_addr=0x005, mem_wdata=0x7F and cpu_ack=1 at t+1; a subsequent CPU read of 0x005 returns cpu_rdata=0x7F with cpu_ack at t+2.
REQ-039 vga_req every cycle with cpu_req read held, STARVE=4 -> CPU denied for 4 edges and granted on the 5th; the VGA request arriving at that edge is served from pending with 3-cycle latency; every VGA request is served and vga_ovf stays 0.
REQ-040 Simultaneous vga_req and cpu_req in the same cycle with wait counter 0 -> VGA issued first, CPU issued the next cycle, cpu_ack exactly once.
REQ-041 A pending VGA request exists, a forced CPU grant occurs, and vga_req arrives at the same edge -> the new request is dropped, vga_ovf=1 and stays 1 until reset.
REQ-042 reset driven low in the cycle after a CPU read issue -> cpu_ack is never asserted for that read, all outputs are 0 during reset, and the first post-reset vga_req is served with 2-cycle latency.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port screen memory shared between a VGA fetcher and a CPU with starvation guard
module vram_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_valid,
    output logic [DW-1:0] vga_data,
    output logic          vga_ovf,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] SAT = CW'(STARVE);

    logic          pend_v_q, pend_v_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d, mem_cpu_q, mem_cpu_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          vga_valid_q, vga_valid_d, cpu_wack_q, cpu_wack_d, cpu_rack_q, cpu_rack_d;
    logic          ovf_q, ovf_d;
    logic          cpu_busy, cpu_elig, forced, gnt_cpu, gnt_pend, gnt_new;

    assign cpu_busy  = mem_en_q & mem_cpu_q & ~mem_we_q;
    assign cpu_ack   = cpu_wack_q | cpu_rack_q;
    assign cpu_elig  = cpu_req & ~cpu_busy & ~cpu_ack;
    assign forced    = cpu_elig & (wait_q == SAT);
    assign gnt_cpu   = forced | (cpu_elig & ~pend_v_q & ~vga_req);
    assign gnt_pend  = ~forced & pend_v_q;
    assign gnt_new   = ~forced & ~pend_v_q & vga_req;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign vga_valid = vga_valid_q;
    assign vga_ovf   = ovf_q;
    // Read data is only presented while its strobe is high, so reset and idle cycles show zero
    assign vga_data  = vga_valid_q ? mem_rdata : '0;
    assign cpu_rdata = cpu_rack_q ? mem_rdata : '0;

    // Arbitrate one access per edge and derive pending-slot, wait-counter and completion state
    always_comb begin
        mem_en_d    = gnt_cpu | gnt_pend | gnt_new;
        mem_we_d    = gnt_cpu & cpu_we;
        mem_cpu_d   = gnt_cpu;
        mem_addr_d  = gnt_cpu ? cpu_addr : gnt_pend ? pend_addr_q : gnt_new ? vga_addr : mem_addr_q;
        mem_wdata_d = mem_we_d ? cpu_wdata : mem_wdata_q;
        pend_v_d    = gnt_pend ? vga_req : pend_v_q | (vga_req & forced);
        pend_addr_d = ((gnt_pend | ~pend_v_q) & vga_req) ? vga_addr : pend_addr_q;
        ovf_d       = ovf_q | (pend_v_q & ~gnt_pend & vga_req);
        wait_d      = (~cpu_elig | gnt_cpu) ? '0 : (wait_q == SAT) ? wait_q : wait_q + CW'(1);
        vga_valid_d = mem_en_q & ~mem_cpu_q;
        cpu_rack_d  = cpu_busy;
        cpu_wack_d  = gnt_cpu & cpu_we;
    end

    // State register; reset drops any in-flight access so no completion follows it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            wait_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_cpu_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vga_valid_q <= 1'b0;
            cpu_wack_q  <= 1'b0;
            cpu_rack_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            wait_q      <= wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_cpu_q   <= mem_cpu_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vga_valid_q <= vga_valid_d;
            cpu_wack_q  <= cpu_wack_d;
            cpu_rack_q  <= cpu_rack_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule
